sprite_blitter: RTL and testbench

Consumes the palette-index glyph arrays from the font ROM block and walks one requested sprite row by row. Emits a stream of opaque, on-screen pixels (screen x, screen y, palette index) over a valid/ready handshake to the downstream frame-buffer writer. One request is accepted at a time. Transparent (index 0) and off-screen pixels are dropped internally.

---
 rtl/sprite_blitter_if.sv | 31 +++
 rtl/sprite_blitter.sv | 168 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: request and pixel-stream handshake between a sprite
// requester / frame-buffer writer (master) and sprite_blitter (slave).
//   req_*   : one sprite request (id, top-left x/y, mirror) with valid/ready
//   pix_*   : stream of opaque on-screen pixels with valid/ready
//   busy    : blitter is walking a sprite
//   done    : one-cycle pulse when a sprite finishes
interface sprite_blitter_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_id;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic       req_mirror;
  logic       pix_valid;
  logic       pix_ready;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [5:0] pix_color;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_id, req_x, req_y, req_mirror, pix_ready,
    input  req_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
  );

  modport slave (
    input  req_valid, req_id, req_x, req_y, req_mirror, pix_ready,
    output req_ready, pix_valid, pix_x, pix_y, pix_color, busy, done
  );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one requested glyph row by row and streams its
// opaque, on-screen pixels (x, y, palette index) to a frame-buffer writer.
// Transparent (index 0) and clipped pixels cost one cycle each and are not
// presented. One request at a time.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   *_font          : static glyph arrays [rows][cols][6-bit index]
//   sif (slave)     : request handshake, pixel stream, busy, done
// Optional feature: define SPRITE_MIRROR_EN to honour req_mirror
// (horizontal flip). Without it req_mirror is ignored.
module sprite_blitter #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0][16:0][5:0]  frog_font,
  input  logic [15:0][24:0][5:0]  firetruck_font,
  input  logic [13:0][18:0][5:0]  bus_font,
  input  logic [15:0][22:0][5:0]  motorcycle_font,
  input  logic [8:0][26:0][5:0]   shortlog_font,
  input  logic [8:0][49:0][5:0]   mediumlog_font,
  input  logic [8:0][72:0][5:0]   longlog_font,
  input  logic [15:0][7:0][5:0]   heart_font,
  sprite_blitter_if.slave         sif
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] id_q, id_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [6:0] w_q, w_d, col_q, col_d;
  logic [4:0] h_q, h_d, row_q, row_d;
  logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [6:0] fc;
  logic [5:0] color;
  logic [10:0] sx, sy;
  logic       emit;

`ifdef SPRITE_MIRROR_EN
  logic mirror_q, mirror_d;
  assign fc = mirror_q ? (w_q - 7'd1 - col_q) : col_q;
`else
  logic unused_mirror;
  assign unused_mirror = sif.req_mirror;
  assign fc = col_q;
`endif

  // Glyph lookup; index widths are trimmed to each array's own extent.
  always_comb begin
    color = '0;
    case (id_q)
      3'd0: color = frog_font[row_q[3:0]][fc[4:0]];
      3'd1: color = firetruck_font[row_q[3:0]][fc[4:0]];
      3'd2: color = bus_font[row_q[3:0]][fc[4:0]];
      3'd3: color = motorcycle_font[row_q[3:0]][fc[4:0]];
      3'd4: color = shortlog_font[row_q[3:0]][fc[4:0]];
      3'd5: color = mediumlog_font[row_q[3:0]][fc[5:0]];
      3'd6: color = longlog_font[row_q[3:0]][fc];
      default: color = heart_font[row_q[3:0]][fc[2:0]];
    endcase
  end

  // 11-bit sums so positions past 1023 clip instead of wrapping on-screen.
  assign sx   = {1'b0, x_q} + {4'b0, col_q};
  assign sy   = {1'b0, y_q} + {6'b0, row_q};
  assign emit = (state_q == SCAN) && (color != 6'd0) &&
                (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));

  // Pixel fields are forced to zero whenever nothing is presented.
  assign sif.pix_valid = emit;
  assign sif.pix_x     = emit ? sx[9:0] : 10'd0;
  assign sif.pix_y     = emit ? sy[9:0] : 10'd0;
  assign sif.pix_color = emit ? color   : 6'd0;
  assign sif.req_ready = ready_q;
  assign sif.busy      = busy_q;
  assign sif.done      = done_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
`ifdef SPRITE_MIRROR_EN
    mirror_d = mirror_q;
`endif
    case (state_q)
      IDLE: begin
        if (sif.req_valid) begin
          id_d  = sif.req_id;
          x_d   = sif.req_x;
          y_d   = sif.req_y;
          col_d = '0;
          row_d = '0;
`ifdef SPRITE_MIRROR_EN
          mirror_d = sif.req_mirror;
`endif
          case (sif.req_id)
            3'd0: begin w_d = 7'd17; h_d = 5'd16; end
            3'd1: begin w_d = 7'd25; h_d = 5'd16; end
            3'd2: begin w_d = 7'd19; h_d = 5'd14; end
            3'd3: begin w_d = 7'd23; h_d = 5'd16; end
            3'd4: begin w_d = 7'd27; h_d = 5'd9;  end
            3'd5: begin w_d = 7'd50; h_d = 5'd9;  end
            3'd6: begin w_d = 7'd73; h_d = 5'd9;  end
            default: begin w_d = 7'd8; h_d = 5'd16; end
          endcase
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Skipped pixels advance every cycle; shown ones wait for pix_ready.
        if (!emit || sif.pix_ready) begin
          if (col_q == w_q - 7'd1) begin
            col_d = '0;
            if (row_q == h_q - 5'd1) state_d = DONE;
            else                     row_d = row_q + 5'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: drives sprite requests into sprite_blitter with bench-
// generated glyphs, predicts the pixel stream from the glyph contents and
// the clipping/transparency rules, and compares every presented pixel and
// the sprite duration. A few glyph cells are fixed so that literal
// expectations (first pixel, row counts, mirror positions) are known.
module tb_sprite_blitter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0][16:0][5:0] frog_font;
  logic [15:0][24:0][5:0] firetruck_font;
  logic [13:0][18:0][5:0] bus_font;
  logic [15:0][22:0][5:0] motorcycle_font;
  logic [8:0][26:0][5:0]  shortlog_font;
  logic [8:0][49:0][5:0]  mediumlog_font;
  logic [8:0][72:0][5:0]  longlog_font;
  logic [15:0][7:0][5:0]  heart_font;

  sprite_blitter_if bif();

  sprite_blitter dut (
    .clk(clk), .rst(rst),
    .frog_font(frog_font), .firetruck_font(firetruck_font),
    .bus_font(bus_font), .motorcycle_font(motorcycle_font),
    .shortlog_font(shortlog_font), .mediumlog_font(mediumlog_font),
    .longlog_font(longlog_font), .heart_font(heart_font),
    .sif(bif)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  int WT[8] = '{17, 25, 19, 23, 27, 50, 73, 8};
  int HT[8] = '{16, 16, 14, 16, 9, 9, 9, 16};

  function automatic int glyph(int id, int r, int c);
    case (id)
      0: return int'(frog_font[r][c]);
      1: return int'(firetruck_font[r][c]);
      2: return int'(bus_font[r][c]);
      3: return int'(motorcycle_font[r][c]);
      4: return int'(shortlog_font[r][c]);
      5: return int'(mediumlog_font[r][c]);
      6: return int'(longlog_font[r][c]);
      default: return int'(heart_font[r][c]);
    endcase
  endfunction

  // Expected stream: raster order, opaque and on-screen pixels only.
  task automatic build_model(int id, int x, int y, int m);
    pix_t p;
    int fc;
    exp_q.delete();
    for (int r = 0; r < HT[id]; r++)
      for (int c = 0; c < WT[id]; c++) begin
`ifdef SPRITE_MIRROR_EN
        fc = (m != 0) ? WT[id] - 1 - c : c;
`else
        fc = c;
`endif
        p.x = x + c; p.y = y + r; p.c = glyph(id, r, fc);
        if (p.c != 0 && p.x < 640 && p.y < 480) exp_q.push_back(p);
      end
  endtask

  function automatic logic [5:0] rnd_color();
    return ($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 63)) : 6'd0;
  endfunction

  int first_cyc, first_x, first_y, first_c, n_xfer, max_x, done_cyc, stalls;
  int r0x[$];

  task automatic drive_req(int id, int x, int y, int m);
    bif.req_id = 3'(id); bif.req_x = 10'(x); bif.req_y = 10'(y);
    bif.req_mirror = m[0];
    bif.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: ready always; 1: random ready; 2: stall first pixel stall_n
  // cycles; 3: ready always, req_valid kept high for early SCAN cycles.
  task automatic run_sprite(int id, int x, int y, int m, int mode, int stall_n);
    int stall_left = stall_n;
    build_model(id, x, y, m);
    @(negedge clk);
    check("idle_req_ready", bif.req_ready, 1);
    drive_req(id, x, y, m);
    if (mode != 3) bif.req_valid = 1'b0;
    else bif.req_id = 3'(id ^ 7);
    first_cyc = -1; n_xfer = 0; max_x = -1; done_cyc = -1; stalls = 0;
    r0x.delete();
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      if (mode == 3 && cyc == 10) bif.req_valid = 1'b0;
      if (mode == 3 && cyc == 5) begin
        check("busy_ignores_req", bif.req_ready, 0);
        check("busy_high", bif.busy, 1);
      end
      case (mode)
        1: bif.pix_ready = ($urandom_range(0, 3) != 0);
        2: begin
          bif.pix_ready = !(bif.pix_valid && stall_left > 0);
          if (bif.pix_valid && stall_left > 0) stall_left--;
        end
        default: bif.pix_ready = 1'b1;
      endcase
      if (bif.done) begin done_cyc = cyc; break; end
      if (bif.pix_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc; first_x = bif.pix_x; first_y = bif.pix_y;
          first_c = bif.pix_color;
        end
        if (exp_q.size() == 0) check("extra_pixel", 1, 0);
        else begin
          checks++;
          if (bif.pix_x == exp_q[0].x && bif.pix_y == exp_q[0].y &&
              bif.pix_color == exp_q[0].c) passed++;
          else $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                        bif.pix_x, bif.pix_y, bif.pix_color,
                        exp_q[0].x, exp_q[0].y, exp_q[0].c);
          if (bif.pix_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
            if (int'(bif.pix_x) > max_x) max_x = bif.pix_x;
            if (int'(bif.pix_y) == y) r0x.push_back(bif.pix_x);
          end else stalls++;
        end
      end
      @(negedge clk);
    end
    if (done_cyc < 0) check("done_timeout", 0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("sprite_cycles", done_cyc, WT[id] * HT[id] + stalls + 1);
    @(negedge clk);
    check("post_done_ready", bif.req_ready, 1);
    check("done_one_cycle", bif.done, 0);
  endtask

  initial begin
    rst = 1'b1;
    bif.req_valid = 1'b0; bif.req_id = '0; bif.req_x = '0; bif.req_y = '0;
    bif.req_mirror = 1'b0; bif.pix_ready = 1'b1;

    for (int r = 0; r < 16; r++) for (int c = 0; c < 17; c++) frog_font[r][c] = rnd_color();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 25; c++) firetruck_font[r][c] = rnd_color();
    for (int r = 0; r < 14; r++) for (int c = 0; c < 19; c++) bus_font[r][c] = rnd_color();
    for (int r = 0; r < 16; r++) for (int c = 0; c < 23; c++) motorcycle_font[r][c] = rnd_color();
    for (int r = 0; r < 9; r++)  for (int c = 0; c < 27; c++) shortlog_font[r][c] = rnd_color();
    for (int r = 0; r < 9; r++)  for (int c = 0; c < 50; c++) mediumlog_font[r][c] = rnd_color();
    for (int r = 0; r < 9; r++)  for (int c = 0; c < 73; c++) longlog_font[r][c] = rnd_color();
    // Fixed cells: frog row 0 = cols 3..8 colour 1; motorcycle row 0 =
    // cols 7,8,10 colour 1; heart has 34 opaque cells starting at (4,1).
    for (int c = 0; c < 17; c++) frog_font[0][c] = (c >= 3 && c <= 8) ? 6'd1 : 6'd0;
    for (int c = 0; c < 23; c++) motorcycle_font[0][c] = (c == 7 || c == 8 || c == 10) ? 6'd1 : 6'd0;
    for (int i = 0; i < 128; i++)
      heart_font[i / 8][i % 8] = (i == 33) ? 6'd1 :
                                 (i > 33 && i <= 66) ? 6'($urandom_range(1, 63)) : 6'd0;
    longlog_font[0][39] = 6'd5;
    bus_font[0][0] = 6'd7;

    #2;
    check("rst_req_ready", bif.req_ready, 1);
    check("rst_pix_valid", bif.pix_valid, 0);
    check("rst_pix_x", bif.pix_x, 0);
    check("rst_pix_y", bif.pix_y, 0);
    check("rst_pix_color", bif.pix_color, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_done", bif.done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Frog at (100,50)
    run_sprite(0, 100, 50, 0, 0, 0);
    check("frog_first_cyc", first_cyc, 4);
    check("frog_first_x", first_x, 103);
    check("frog_first_y", first_y, 50);
    check("frog_first_c", first_c, 1);
    check("frog_row0_cnt", r0x.size(), 6);
    check("frog_done_cyc", done_cyc, 273);

    // Heart at (0,0)
    run_sprite(7, 0, 0, 0, 0, 0);
    check("heart_first_cyc", first_cyc, 34);
    check("heart_first_x", first_x, 1);
    check("heart_first_y", first_y, 4);
    check("heart_first_c", first_c, 1);
    check("heart_total", n_xfer, 34);

    // Longlog at (600,10): right edge clipped
    run_sprite(6, 600, 10, 0, 0, 0);
    check("longlog_max_x", max_x, 639);
    check("longlog_done_cyc", done_cyc, 658);

    // Bus at (5,5) with a 5-cycle stall on the first pixel
    run_sprite(2, 5, 5, 0, 2, 5);
    check("bus_stalls", stalls, 5);
    check("bus_done_cyc", done_cyc, 19 * 14 + 5 + 1);

    // Motorcycle at (200,100) with mirror requested
    run_sprite(3, 200, 100, 1, 0, 0);
    check("moto_row0_cnt", r0x.size(), 3);
    begin
`ifdef SPRITE_MIRROR_EN
      int ex[3] = '{212, 214, 215};
`else
      int ex[3] = '{207, 208, 210};
`endif
      for (int i = 0; i < 3; i++)
        check("moto_row0_x", (r0x.size() > i) ? r0x[i] : -1, ex[i]);
    end

    // Request held during busy is ignored
    run_sprite(1, 30, 30, 0, 3, 0);

    // Reset mid-SCAN
    @(negedge clk);
    drive_req(0, 100, 50, 0);
    bif.req_valid = 1'b0;
    bif.pix_ready = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pix_valid", bif.pix_valid, 0);
    check("midrst_req_ready", bif.req_ready, 1);
    check("midrst_busy", bif.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sprite(0, 100, 50, 0, 0, 0);
    check("post_rst_first_cyc", first_cyc, 4);
    check("post_rst_first_x", first_x, 103);

    // Randomized requests with random backpressure
    for (int n = 0; n < 10; n++)
      run_sprite($urandom_range(0, 7), $urandom_range(0, 660), $urandom_range(0, 490),
                 $urandom_range(0, 1), 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
